// File: rtl/id_exe_reg_pkg.sv
// Shared pipeline definitions for the decode/execute boundary of the 32-bit ARM core.
package id_exe_reg_pkg;

  localparam int BIT_NUMBER_DEF   = 32;
  localparam int REG_NUM_BITS_DEF = 4;

  // ALU command encodings; compare/test and load/store reuse the arithmetic/logic codes
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b0110;
  localparam logic [3:0] CMD_LDR = 4'b0010;
  localparam logic [3:0] CMD_STR = 4'b0010;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  // Control bits cleared by a flush
  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic b;
    logic s;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_exe_reg_hazard_unit.sv
// Combinational read-after-write detector against the EXE and MEM destinations.
module hazard_unit
  import id_exe_reg_pkg::*;
#(
  parameter int REG_NUM_BITS = REG_NUM_BITS_DEF
) (
  input  logic [REG_NUM_BITS-1:0] src1,
  input  logic [REG_NUM_BITS-1:0] src2,
  input  logic                    two_src,
  input  logic                    exe_wb_en,
  input  logic [REG_NUM_BITS-1:0] exe_dest,
  input  logic                    mem_wb_en,
  input  logic [REG_NUM_BITS-1:0] mem_dest,
  output logic                    hazard
);

  logic exe_match;
  logic mem_match;

  // R0 is an ordinary register here, so no zero-index exclusion
  always_comb begin
    exe_match = exe_wb_en && ((exe_dest == src1) || (two_src && (exe_dest == src2)));
    mem_match = mem_wb_en && ((mem_dest == src1) || (two_src && (mem_dest == src2)));
    hazard    = exe_match || mem_match;
  end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with stall hold, branch bubble, NZCV status register
// and data-hazard detection fed back to decode.
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int BIT_NUMBER   = BIT_NUMBER_DEF,
  parameter int REG_NUM_BITS = REG_NUM_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic                    id_wb_en,
  input  logic                    id_mem_r_en,
  input  logic                    id_mem_w_en,
  input  logic                    id_b,
  input  logic                    id_s,
  input  logic                    id_imm,
  input  logic [REG_NUM_BITS-1:0] id_exe_cmd,
  input  logic [REG_NUM_BITS-1:0] id_dest,
  input  logic [REG_NUM_BITS-1:0] id_first_src,
  input  logic [REG_NUM_BITS-1:0] id_second_src,
  input  logic                    id_two_src,
  input  logic [11:0]             id_shift_operand,
  input  logic [23:0]             id_signed_imm_24,
  input  logic [BIT_NUMBER-1:0]   id_pc,
  input  logic [BIT_NUMBER-1:0]   id_val_rn,
  input  logic [BIT_NUMBER-1:0]   id_val_rm,
  input  logic [REG_NUM_BITS-1:0] mem_dest,
  input  logic                    mem_wb_en,
  input  logic [3:0]              exe_status,
  output logic                    exe_wb_en,
  output logic                    exe_mem_r_en,
  output logic                    exe_mem_w_en,
  output logic                    exe_b,
  output logic                    exe_s,
  output logic                    exe_imm,
  output logic [REG_NUM_BITS-1:0] exe_exe_cmd,
  output logic [REG_NUM_BITS-1:0] exe_dest,
  output logic [11:0]             exe_shift_operand,
  output logic [23:0]             exe_signed_imm_24,
  output logic [BIT_NUMBER-1:0]   exe_pc,
  output logic [BIT_NUMBER-1:0]   exe_val_rn,
  output logic [BIT_NUMBER-1:0]   exe_val_rm,
  output logic                    hazard,
  output logic [3:0]              sr
);

  ctrl_t                   ctrl_d, ctrl_q;
  logic [REG_NUM_BITS-1:0] cmd_d, cmd_q;
  logic [REG_NUM_BITS-1:0] dest_d, dest_q;
  logic                    imm_d, imm_q;
  logic [11:0]             shift_d, shift_q;
  logic [23:0]             simm_d, simm_q;
  logic [BIT_NUMBER-1:0]   pc_d, pc_q;
  logic [BIT_NUMBER-1:0]   rn_d, rn_q;
  logic [BIT_NUMBER-1:0]   rm_d, rm_q;
  logic [3:0]              sr_d, sr_q;

  always_comb begin
    ctrl_d  = ctrl_q;
    cmd_d   = cmd_q;
    dest_d  = dest_q;
    imm_d   = imm_q;
    shift_d = shift_q;
    simm_d  = simm_q;
    pc_d    = pc_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    sr_d    = sr_q;
    if (!freeze) begin
      ctrl_d.wb_en    = id_wb_en;
      ctrl_d.mem_r_en = id_mem_r_en;
      ctrl_d.mem_w_en = id_mem_w_en;
      ctrl_d.b        = id_b;
      ctrl_d.s        = id_s;
      cmd_d           = id_exe_cmd;
      dest_d          = id_dest;
      imm_d           = id_imm;
      shift_d         = id_shift_operand;
      simm_d          = id_signed_imm_24;
      pc_d            = id_pc;
      rn_d            = id_val_rn;
      rm_d            = id_val_rm;
      if (flush) begin
        ctrl_d = CTRL_BUBBLE;
        cmd_d  = '0;
      end
      // Flags belong to the instruction already in EXE, so flush of the incoming one is irrelevant
      if (ctrl_q.s) sr_d = exe_status;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= CTRL_BUBBLE;
      cmd_q   <= '0;
      dest_q  <= '0;
      imm_q   <= 1'b0;
      shift_q <= '0;
      simm_q  <= '0;
      pc_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      sr_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      cmd_q   <= cmd_d;
      dest_q  <= dest_d;
      imm_q   <= imm_d;
      shift_q <= shift_d;
      simm_q  <= simm_d;
      pc_q    <= pc_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      sr_q    <= sr_d;
    end
  end

  assign exe_wb_en         = ctrl_q.wb_en;
  assign exe_mem_r_en      = ctrl_q.mem_r_en;
  assign exe_mem_w_en      = ctrl_q.mem_w_en;
  assign exe_b             = ctrl_q.b;
  assign exe_s             = ctrl_q.s;
  assign exe_imm           = imm_q;
  assign exe_exe_cmd       = cmd_q;
  assign exe_dest          = dest_q;
  assign exe_shift_operand = shift_q;
  assign exe_signed_imm_24 = simm_q;
  assign exe_pc            = pc_q;
  assign exe_val_rn        = rn_q;
  assign exe_val_rm        = rm_q;
  assign sr                = sr_q;

  hazard_unit #(
    .REG_NUM_BITS (REG_NUM_BITS)
  ) u_hazard_unit (
    .src1      (id_first_src),
    .src2      (id_second_src),
    .two_src   (id_two_src),
    .exe_wb_en (ctrl_q.wb_en),
    .exe_dest  (dest_q),
    .mem_wb_en (mem_wb_en),
    .mem_dest  (mem_dest),
    .hazard    (hazard)
  );

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: directed vector table, hand-written corner sequences,
// and randomized traffic against a behavioural model of the stage.
module tb_id_exe_reg;
  import id_exe_reg_pkg::*;

  logic        clk, rst, freeze, flush;
  logic        id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm, id_two_src;
  logic [3:0]  id_exe_cmd, id_dest, id_first_src, id_second_src, mem_dest;
  logic [11:0] id_shift_operand;
  logic [23:0] id_signed_imm_24;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic        mem_wb_en;
  logic [3:0]  exe_status;
  logic        exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm;
  logic [3:0]  exe_exe_cmd, exe_dest;
  logic [11:0] exe_shift_operand;
  logic [23:0] exe_signed_imm_24;
  logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
  logic        hazard;
  logic [3:0]  sr;

  id_exe_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .id_b(id_b), .id_s(id_s), .id_imm(id_imm),
    .id_exe_cmd(id_exe_cmd), .id_dest(id_dest), .id_first_src(id_first_src),
    .id_second_src(id_second_src), .id_two_src(id_two_src),
    .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
    .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .exe_status(exe_status),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
    .exe_b(exe_b), .exe_s(exe_s), .exe_imm(exe_imm),
    .exe_exe_cmd(exe_exe_cmd), .exe_dest(exe_dest),
    .exe_shift_operand(exe_shift_operand), .exe_signed_imm_24(exe_signed_imm_24),
    .exe_pc(exe_pc), .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm),
    .hazard(hazard), .sr(sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb, mr, mw, b, s, imm;
    logic [3:0]  cmd, dest;
    logic [11:0] shift;
    logic [23:0] simm;
    logic [31:0] pc, rn, rm;
    logic [3:0]  sr;
  } obs_t;

  typedef struct {
    logic        fr, fl, wb, mw, b, s;
    logic [3:0]  cmd, dest;
    logic [31:0] rn;
    logic [3:0]  st;
    logic        e_wb, e_mw, e_b, e_s;
    logic [3:0]  e_cmd, e_dest;
    logic [31:0] e_rn;
    logic [3:0]  e_sr;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  obs_t m;
  vec_t vecs[14];

  function automatic obs_t get_obs();
    return {exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm,
            exe_exe_cmd, exe_dest, exe_shift_operand, exe_signed_imm_24,
            exe_pc, exe_val_rn, exe_val_rm, sr};
  endfunction

  // What the stage should hold after the next edge, from the current inputs and model state
  function automatic obs_t model_next();
    obs_t n;
    if (rst) return '0;
    if (freeze) return m;
    n.sr    = m.s ? exe_status : m.sr;
    n.wb    = flush ? 1'b0 : id_wb_en;
    n.mr    = flush ? 1'b0 : id_mem_r_en;
    n.mw    = flush ? 1'b0 : id_mem_w_en;
    n.b     = flush ? 1'b0 : id_b;
    n.s     = flush ? 1'b0 : id_s;
    n.cmd   = flush ? 4'd0 : id_exe_cmd;
    n.imm   = id_imm;
    n.dest  = id_dest;
    n.shift = id_shift_operand;
    n.simm  = id_signed_imm_24;
    n.pc    = id_pc;
    n.rn    = id_val_rn;
    n.rm    = id_val_rm;
    return n;
  endfunction

  function automatic logic model_hazard();
    logic [3:0] used[$];
    logic       h = 1'b0;
    used.push_back(id_first_src);
    if (id_two_src) used.push_back(id_second_src);
    foreach (used[i]) begin
      if (m.wb && m.dest == used[i]) h = 1'b1;
      if (mem_wb_en && mem_dest == used[i]) h = 1'b1;
    end
    return h;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    freeze = 0; flush = 0;
    id_wb_en = 0; id_mem_r_en = 0; id_mem_w_en = 0; id_b = 0; id_s = 0; id_imm = 0;
    id_exe_cmd = 0; id_dest = 0; id_first_src = 0; id_second_src = 0; id_two_src = 0;
    id_shift_operand = 0; id_signed_imm_24 = 0; id_pc = 0; id_val_rn = 0; id_val_rm = 0;
    mem_dest = 0; mem_wb_en = 0; exe_status = 0;
  endtask

  task automatic randomize_inputs();
    freeze           = ($urandom_range(0, 3) == 0);
    flush            = ($urandom_range(0, 3) == 0);
    id_wb_en         = 1'($urandom);
    id_mem_r_en      = 1'($urandom);
    id_mem_w_en      = 1'($urandom);
    id_b             = 1'($urandom);
    id_s             = 1'($urandom);
    id_imm           = 1'($urandom);
    id_exe_cmd       = 4'($urandom);
    id_dest          = 4'($urandom_range(0, 3));
    id_first_src     = 4'($urandom_range(0, 3));
    id_second_src    = 4'($urandom_range(0, 3));
    id_two_src       = 1'($urandom);
    id_shift_operand = 12'($urandom);
    id_signed_imm_24 = 24'($urandom);
    id_pc            = $urandom;
    id_val_rn        = $urandom;
    id_val_rm        = $urandom;
    mem_dest         = 4'($urandom_range(0, 3));
    mem_wb_en        = 1'($urandom);
    exe_status       = 4'($urandom);
  endtask

  initial begin
    //          fr    fl    wb    mw    b     s     cmd   dest  rn            st      e_wb  e_mw  e_b   e_s   e_cmd e_dest e_rn        e_sr
    vecs[0]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0,4'd5,32'hDEADBEEF,4'h0, 1'b1,1'b0,1'b0,1'b0,4'd0,4'd5,32'hDEADBEEF,4'h0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,4'd3,4'd9,32'h11111111,4'hF, 1'b1,1'b0,1'b0,1'b0,4'd0,4'd5,32'hDEADBEEF,4'h0};
    vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'd7,4'd2,32'h12345678,4'h0, 1'b1,1'b0,1'b0,1'b0,4'd0,4'd5,32'hDEADBEEF,4'h0};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,4'd4,4'd4,32'h00000000,4'h5, 1'b1,1'b0,1'b0,1'b0,4'd0,4'd5,32'hDEADBEEF,4'h0};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,4'd4,4'd6,32'h22222222,4'h0, 1'b0,1'b0,1'b0,1'b0,4'd0,4'd6,32'h22222222,4'h0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,4'd2,4'd1,32'h00000003,4'hF, 1'b0,1'b1,1'b1,1'b1,4'd2,4'd1,32'h00000003,4'h0};
    vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4'd9,4'd7,32'h00000008,4'hA, 1'b0,1'b1,1'b1,1'b1,4'd2,4'd1,32'h00000003,4'h0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd2,32'h00000004,4'hA, 1'b0,1'b0,1'b0,1'b0,4'd0,4'd2,32'h00000004,4'hA};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd1,4'd3,32'h00000005,4'h5, 1'b1,1'b0,1'b0,1'b0,4'd1,4'd3,32'h00000005,4'hA};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd7,4'd8,32'h00000006,4'h0, 1'b0,1'b0,1'b0,1'b1,4'd7,4'd8,32'h00000006,4'hA};
    vecs[10] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,4'd5,4'd9,32'h00000007,4'h3, 1'b0,1'b0,1'b0,1'b0,4'd0,4'd9,32'h00000007,4'h3};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd2,4'd1,32'h00000009,4'h6, 1'b0,1'b0,1'b0,1'b1,4'd2,4'd1,32'h00000009,4'h3};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,32'h00000000,4'h6, 1'b0,1'b0,1'b0,1'b1,4'd2,4'd1,32'h00000009,4'h3};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,32'h00000000,4'h6, 1'b0,1'b0,1'b0,1'b0,4'd0,4'd0,32'h00000000,4'h6};

    // Reset state, and R0 raising a MEM hazard while in reset
    rst = 1'b1;
    clear_inputs();
    #2;
    chk("reset_outputs", get_obs(), '0);
    chk("reset_hazard", hazard, 1'b0);
    mem_wb_en = 1; mem_dest = 0; id_first_src = 0;
    #1;
    chk("reset_r0_mem_hazard", hazard, 1'b1);
    mem_wb_en = 0;
    step();
    rst = 1'b0;

    // Reset mid-operation clears before the next edge
    id_wb_en = 1; id_exe_cmd = 4'b0010; id_pc = 32'h10;
    step();
    chk("load_before_reset", {exe_wb_en, exe_exe_cmd, exe_pc}, {1'b1, 4'b0010, 32'h10});
    #2 rst = 1'b1;
    #1 chk("async_reset_clear", get_obs(), '0);
    // Reset during a stall, released with freeze low: next edge captures normally
    freeze = 1;
    step();
    #2 rst = 1'b0; freeze = 0;
    id_dest = 4'd11; id_val_rm = 32'hCAFEF00D;
    step();
    chk("capture_after_reset", {exe_wb_en, exe_dest, exe_val_rm}, {1'b1, 4'd11, 32'hCAFEF00D});

    // Directed vector table from a clean reset
    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      freeze = vecs[i].fr; flush = vecs[i].fl;
      id_wb_en = vecs[i].wb; id_mem_w_en = vecs[i].mw; id_b = vecs[i].b; id_s = vecs[i].s;
      id_exe_cmd = vecs[i].cmd; id_dest = vecs[i].dest; id_val_rn = vecs[i].rn;
      exe_status = vecs[i].st;
      step();
      chk($sformatf("vec%0d", i),
          {exe_wb_en, exe_mem_w_en, exe_b, exe_s, exe_exe_cmd, exe_dest, exe_val_rn, sr},
          {vecs[i].e_wb, vecs[i].e_mw, vecs[i].e_b, vecs[i].e_s, vecs[i].e_cmd,
           vecs[i].e_dest, vecs[i].e_rn, vecs[i].e_sr});
    end

    // Hazard: EXE holds a write to R3
    clear_inputs();
    id_wb_en = 1; id_dest = 3;
    step();
    id_first_src = 3;
    #1 chk("haz_exe_src1", hazard, 1'b1);
    id_first_src = 4; id_second_src = 3; id_two_src = 0;
    #1 chk("haz_exe_src2_unused", hazard, 1'b0);
    id_two_src = 1;
    #1 chk("haz_exe_src2_used", hazard, 1'b1);
    freeze = 1;
    #1 chk("haz_not_gated_by_freeze", hazard, 1'b1);
    freeze = 0;
    // Hazard: MEM writes R7
    id_second_src = 7; mem_wb_en = 1; mem_dest = 7;
    #1 chk("haz_mem_src2", hazard, 1'b1);
    mem_wb_en = 0;
    #1 chk("haz_mem_dropped", hazard, 1'b0);

    // Randomized traffic against the model
    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    m = '0;
    step();
    for (int i = 0; i < 400; i++) begin
      obs_t n;
      randomize_inputs();
      rst = ($urandom_range(0, 19) == 0);
      #1;
      if (rst) m = '0;
      chk("rand_hazard", hazard, model_hazard());
      chk("rand_async", get_obs(), m);
      n = model_next();
      step();
      m = n;
      chk("rand_outputs", get_obs(), m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
# id_exe_reg

Pipeline register between the decode stage and the execute stage of the 32-bit ARM pipeline. It captures the decoded bundle every cycle and holds it during a memory stall. It inserts a bubble when a branch is taken. It also produces the two feedback signals the decode stage consumes: the data-hazard stall and the 4-bit NZCV status register used by condition checking.

## Interface
- BIT_NUMBER, 32, datapath width (pc, val_rn, val_rm)
- REG_NUM_BITS, 4, register-index and exe_cmd width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  memory stall; hold all state
- flush  in  1  branch taken in EXE; squash the captured bundle
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm  in  1 each  decoded controls
- id_exe_cmd, id_dest, id_first_src, id_second_src  in  REG_NUM_BITS each
- id_two_src  in  1  second source register is read
- id_shift_operand  in  12
- id_signed_imm_24  in  24
- id_pc, id_val_rn, id_val_rm  in  BIT_NUMBER each
- mem_dest  in  REG_NUM_BITS  destination register in the MEM stage
- mem_wb_en  in  1  MEM stage writes back
- exe_status  in  4  NZCV computed by the ALU this cycle
- exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm  out  1 each  registered controls
- exe_exe_cmd, exe_dest  out  REG_NUM_BITS
- exe_shift_operand  out  12
- exe_signed_imm_24  out  24
- exe_pc, exe_val_rn, exe_val_rm  out  BIT_NUMBER
- hazard  out  1  stall request to decode and fetch
- sr  out  4  status register {N,Z,C,V}

## Operation
- Capture: on each rising clk with freeze=0, every exe_* output loads its id_* input.
- Freeze: when freeze=1, all exe_* outputs and sr hold. freeze overrides flush. A flush seen while frozen is dropped, so EXE must keep flush asserted until freeze falls.
- Flush: when flush=1 and freeze=0, the control bits exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s and exe_exe_cmd load 0. Data fields (pc, val_*, shift_operand, signed_imm_24, dest, imm) still load from id_* and are don't-care.
- Hazard is combinational from the current inputs and registered state:
  - an EXE match is exe_wb_en=1 and exe_dest equal to a used source;
  - a MEM match is mem_wb_en=1 and mem_dest equal to a used source;
  - id_first_src is always a used source; id_second_src is used only when id_two_src=1;
  - hazard = EXE match OR MEM match.
- Hazard is not gated by freeze. The decode stage turns hazard into a bubble on the id_* controls, and this block simply captures that bubble.
- Status register: on a rising clk with freeze=0 and exe_s=1, sr loads exe_status. exe_s is the registered bit, so the instruction currently in EXE updates its own flags. This happens regardless of flush in the same cycle, because the flushed instruction is the one being loaded, not the one in EXE.

## Timing
- Reset (asynchronous, immediate):
  - all exe_* outputs are 0 and sr is 4'b0000;
  - hazard then evaluates from the zeroed state, so it is 0 because exe_wb_en=0, unless mem_wb_en drives a match.
- Latency: id_* to exe_* is 1 cycle.
- Latency: exe_status to sr is 1 cycle after the edge on which exe_s=1.
- Latency: hazard has 0 cycles of latency (combinational).
- Reset asserted mid-stall or mid-flush: the outputs clear at once. After rst falls, the first edge with freeze=0 captures normally.
- Simultaneous freeze=1 and flush=1: the block holds; see Operation.
- Register index 0 is not special. R0 as a source still raises hazards.

## Structure
- Shared package, pipeline defs:
  - BIT_NUMBER and REG_NUM_BITS defaults;
  - exe_cmd encodings (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP, TST, LDR, STR);
  - NZCV bit positions N=3, Z=2, C=1, V=0.
- Sub-module hazard_unit: purely combinational comparator producing hazard. It is instantiated once here and is reused later if forwarding is added.
- The status register stays inline (a 4-bit enabled flop).

## Test plan
- Reset mid-operation: load id_wb_en=1, id_exe_cmd=4'b0010, id_pc=32'h10, then pulse rst asynchronously -> all exe_* are 0 and sr=0 immediately, before the next clk edge.
- Capture:
  - stimulus: id_val_rn=32'hDEADBEEF, id_dest=4'd5, id_wb_en=1 for one cycle;
  - next-edge response: exe_val_rn=32'hDEADBEEF, exe_dest=5, exe_wb_en=1;
  - then set freeze=1 for 3 cycles with changing id_* -> outputs unchanged.
- Flush:
  - stimulus: flush=1, freeze=0, id_mem_w_en=1, id_b=1, id_exe_cmd=4'b0100;
  - response: exe_mem_w_en=0, exe_b=0, exe_exe_cmd=0;
  - repeat with freeze=1 -> previous contents held.
- Hazard, EXE case: exe_wb_en=1 and exe_dest=3.
  - id_first_src=3 -> hazard=1.
  - id_first_src=4, id_second_src=3, id_two_src=0 -> hazard=0.
  - Same, but id_two_src=1 -> hazard=1.
- Hazard, MEM case: mem_wb_en=1, mem_dest=7, id_second_src=7, id_two_src=1 -> hazard=1. Dropping mem_wb_en -> hazard=0.
- Status update:
  - EXE holds an instruction with exe_s=1 and exe_status=4'b1010 -> sr=4'b1010 after the edge.
  - With exe_s=0 and exe_status=4'b0101 -> sr stays 4'b1010.
  - With freeze=1 and exe_s=1 -> sr holds.
